mem_bus_ctrl: RTL and testbench

Memory bus controller sitting directly downstream of the memory bus arbiter. It consumes the arbiter's bus enable, read/write and per-master grant outputs, muxes the granted master's address and write data, and executes one complete access on the external asynchronous SRAM with programmable wait states. It returns read data and a one-cycle done pulse to the L2 or DSC master that owned the access. Once started, an access cannot be aborted.

---
 rtl/mem_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Memory bus controller placed after the bus arbiter. It
//               latches the granted master's request and runs one complete,
//               non-abortable access on an asynchronous SRAM. Read and write
//               wait states and post-access bus turnaround are programmable.
//               Read data and a one-cycle done pulse go back to the master
//               that owned the access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int RD_WAIT    = 2,
    parameter int WR_WAIT    = 1,
    parameter int TURNAROUND = 1
) (
    input  logic              clk_166M66,
    input  logic              mcu_sys_rst_n,
    input  logic              i_data_bus_enable,
    input  logic              i_data_bus_rw,
    input  logic              i_l2_allow,
    input  logic              i_dsc_allow,
    input  logic [ADDR_W-1:0] i_l2_addr,
    input  logic [DATA_W-1:0] i_l2_wdata,
    input  logic [ADDR_W-1:0] i_dsc_addr,
    input  logic [DATA_W-1:0] i_dsc_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_l2_done,
    output logic              o_dsc_done,
    output logic              o_grant_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ce_n,
    output logic              o_mem_oe_n,
    output logic              o_mem_we_n,
    output logic [DATA_W-1:0] o_mem_dq_out,
    output logic              o_mem_dq_oe,
    input  logic [DATA_W-1:0] i_mem_dq_in
);

    // Counter load values; the counter is 3 bits wide (wait states 0..7).
    localparam logic [2:0] c_RD_LOAD   = 3'(RD_WAIT);
    localparam logic [2:0] c_WR_LOAD   = 3'(WR_WAIT);
    localparam logic [2:0] c_TURN_LOAD = (TURNAROUND > 0) ? 3'(TURNAROUND - 1) : 3'd0;
    localparam bit         c_HAS_TURN  = (TURNAROUND > 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_TURN   = 3'd4
    } state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              rw_q;       // 1 = write
    logic              src_dsc_q;  // 1 = DSC owns the access, 0 = L2
    logic [DATA_W-1:0] rdata_q;
    logic              l2_done_q;
    logic              dsc_done_q;
    logic              grant_err_q;
    logic              busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic [DATA_W-1:0] dq_out_q;
    logic              dq_oe_q;

    logic w_one_allow;
    logic w_both_allow;

    assign w_one_allow  = i_l2_allow ^ i_dsc_allow;
    assign w_both_allow = i_l2_allow & i_dsc_allow;

    // Access sequencer: every output is registered as the value it must
    // hold in the state being entered, so strobes never glitch.
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            rw_q        <= 1'b0;
            src_dsc_q   <= 1'b0;
            rdata_q     <= '0;
            l2_done_q   <= 1'b0;
            dsc_done_q  <= 1'b0;
            grant_err_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            l2_done_q   <= 1'b0;
            dsc_done_q  <= 1'b0;
            grant_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (i_data_bus_enable && w_both_allow) begin
                        // Ambiguous grant: flag it and start nothing.
                        grant_err_q <= 1'b1;
                    end else if (i_data_bus_enable && w_one_allow) begin
                        // Address and write data are captured once here and
                        // held on the SRAM pins for the whole access.
                        state_q    <= S_SETUP;
                        busy_q     <= 1'b1;
                        rw_q       <= i_data_bus_rw;
                        src_dsc_q  <= i_dsc_allow;
                        mem_addr_q <= i_dsc_allow ? i_dsc_addr : i_l2_addr;
                        ce_n_q     <= 1'b0;
                        if (i_data_bus_rw) begin
                            dq_oe_q  <= 1'b1;
                            dq_out_q <= i_dsc_allow ? i_dsc_wdata : i_l2_wdata;
                        end else begin
                            oe_n_q <= 1'b0;
                        end
                    end
                end

                S_SETUP: begin
                    // Address has had one cycle of setup; open the strobe.
                    state_q <= S_ACCESS;
                    cnt_q   <= rw_q ? c_WR_LOAD : c_RD_LOAD;
                    if (rw_q) begin
                        we_n_q <= 1'b0;
                    end
                end

                S_ACCESS: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_DONE;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        // dq_oe is left as is so write data is held past we_n.
                        if (!rw_q) begin
                            rdata_q <= i_mem_dq_in;
                        end
                        l2_done_q  <= ~src_dsc_q;
                        dsc_done_q <= src_dsc_q;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                S_DONE: begin
                    dq_oe_q <= 1'b0;
                    if (c_HAS_TURN) begin
                        state_q <= S_TURN;
                        cnt_q   <= c_TURN_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                S_TURN: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdata      = rdata_q;
    assign o_l2_done    = l2_done_q;
    assign o_dsc_done   = dsc_done_q;
    assign o_grant_err  = grant_err_q;
    assign o_busy       = busy_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_ce_n   = ce_n_q;
    assign o_mem_oe_n   = oe_n_q;
    assign o_mem_we_n   = we_n_q;
    assign o_mem_dq_out = dq_out_q;
    assign o_mem_dq_oe  = dq_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Scoreboard bench for mem_bus_ctrl. Stimulus pushes expected
//               done / grant-error events; a monitor pops and compares them
//               when the DUT pulses. Strobe timing is checked cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int RD_W   = 2;
    localparam int WR_W   = 1;
    localparam int TA     = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              rw = 1'b0;
    logic              l2_allow = 1'b0;
    logic              dsc_allow = 1'b0;
    logic [ADDR_W-1:0] l2_addr = '0;
    logic [DATA_W-1:0] l2_wdata = '0;
    logic [ADDR_W-1:0] dsc_addr = '0;
    logic [DATA_W-1:0] dsc_wdata = '0;
    logic [DATA_W-1:0] dq_in = '0;
    logic [DATA_W-1:0] rdata;
    logic              l2_done, dsc_done, grant_err, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              ce_n, oe_n, we_n, dq_oe;
    logic [DATA_W-1:0] dq_out;

    mem_bus_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_W), .WR_WAIT(WR_W), .TURNAROUND(TA)
    ) dut (
        .clk_166M66(clk),
        .mcu_sys_rst_n(rst_n),
        .i_data_bus_enable(en),
        .i_data_bus_rw(rw),
        .i_l2_allow(l2_allow),
        .i_dsc_allow(dsc_allow),
        .i_l2_addr(l2_addr),
        .i_l2_wdata(l2_wdata),
        .i_dsc_addr(dsc_addr),
        .i_dsc_wdata(dsc_wdata),
        .o_rdata(rdata),
        .o_l2_done(l2_done),
        .o_dsc_done(dsc_done),
        .o_grant_err(grant_err),
        .o_busy(busy),
        .o_mem_addr(mem_addr),
        .o_mem_ce_n(ce_n),
        .o_mem_oe_n(oe_n),
        .o_mem_we_n(we_n),
        .o_mem_dq_out(dq_out),
        .o_mem_dq_oe(dq_oe),
        .i_mem_dq_in(dq_in)
    );

    always #3 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]        kind_oh;  // {grant_err, dsc_done, l2_done}
        logic [DATA_W-1:0] rdata;
        int                at_cyc;
    } exp_t;

    exp_t              sb[$];
    int                vectors = 0;
    int                miscompares = 0;
    logic [DATA_W-1:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done / error pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (l2_done || dsc_done || grant_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {29'd0, grant_err, dsc_done, l2_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_kind", {29'd0, grant_err, dsc_done, l2_done}, {29'd0, e.kind_oh});
                chk("event_cycle", cyc, e.at_cyc);
                if (!e.kind_oh[2]) chk("rdata_at_done", {16'd0, rdata}, {16'd0, e.rdata});
            end
        end
    end

    task automatic drop_req();
        en = 1'b0; l2_allow = 1'b0; dsc_allow = 1'b0;
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_ce_n"}, {31'd0, ce_n}, 32'd1);
        chk({tag, "_oe_n"}, {31'd0, oe_n}, 32'd1);
        chk({tag, "_we_n"}, {31'd0, we_n}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // One access with per-cycle strobe checks. late_drop holds the request
    // into cycle 2 and then scrambles addresses/data to prove they are latched.
    task automatic access(input bit dsc, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                          input bit late_drop);
        int   w, t0;
        exp_t e;
        bit   ce_e, oe_e, we_e, oe_dq_e, busy_e;
        w = wr ? WR_W : RD_W;
        @(negedge clk);
        t0 = cyc;
        en = 1'b1; rw = wr; l2_allow = !dsc; dsc_allow = dsc;
        if (dsc) begin
            dsc_addr = a; dsc_wdata = wd; l2_addr = ~a; l2_wdata = ~wd;
        end else begin
            l2_addr = a; l2_wdata = wd; dsc_addr = ~a; dsc_wdata = ~wd;
        end
        dq_in = rd;
        if (!wr) last_rd = rd;
        e.kind_oh = dsc ? 3'b010 : 3'b001;
        e.rdata   = last_rd;
        e.at_cyc  = t0 + 3 + w;
        sb.push_back(e);
        for (int k = 1; k <= 4 + w + TA; k++) begin
            @(negedge clk);
            ce_e    = (k >= 1 && k <= 2 + w);
            oe_e    = !wr && (k >= 1 && k <= 2 + w);
            we_e    = wr && (k >= 2 && k <= 2 + w);
            oe_dq_e = wr && (k >= 1 && k <= 3 + w);
            busy_e  = (k >= 1 && k <= 3 + w + TA);
            chk("ce_n", {31'd0, ce_n}, {31'd0, !ce_e});
            chk("oe_n", {31'd0, oe_n}, {31'd0, !oe_e});
            chk("we_n", {31'd0, we_n}, {31'd0, !we_e});
            chk("dq_oe", {31'd0, dq_oe}, {31'd0, oe_dq_e});
            chk("busy", {31'd0, busy}, {31'd0, busy_e});
            if (k <= 2 + w) chk("mem_addr", {12'd0, mem_addr}, {12'd0, a});
            if (oe_dq_e) chk("dq_out", {16'd0, dq_out}, {16'd0, wd});
            if (k == 1 && !late_drop) drop_req();
            if (k == 2 && late_drop) begin
                drop_req();
                l2_addr = 20'h0F0F0; dsc_addr = 20'h0F0F0;
                l2_wdata = 16'h5A5A; dsc_wdata = 16'h5A5A;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, checked while held and after release.
        repeat (3) @(negedge clk);
        chk_idle_pins("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_pins("rst_rel");
        chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("rst_addr", {12'd0, mem_addr}, 32'd0);
        chk("rst_dq_out", {16'd0, dq_out}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_pulses", {29'd0, l2_done, dsc_done, grant_err}, 32'd0);

        // L2 read, DSC write, DSC read, L2 write.
        access(1'b0, 1'b0, 20'h00ABC, 16'h0000, 16'hA5A5, 1'b0);
        access(1'b1, 1'b1, 20'h12345, 16'hBEEF, 16'h1111, 1'b0);
        access(1'b1, 1'b0, 20'hFFFFF, 16'h0000, 16'h3C3C, 1'b0);
        access(1'b0, 1'b1, 20'h00000, 16'hFFFF, 16'h2222, 1'b0);

        // Request withdrawn and addresses changed mid-access.
        access(1'b0, 1'b0, 20'h0C0DE, 16'h0000, 16'h7E81, 1'b1);
        access(1'b1, 1'b1, 20'h0BEAD, 16'hCAFE, 16'h0000, 1'b1);

        // Both allows high: one error pulse, no access.
        @(negedge clk);
        begin
            exp_t e;
            e.kind_oh = 3'b100; e.rdata = '0; e.at_cyc = cyc + 1;
            sb.push_back(e);
        end
        en = 1'b1; l2_allow = 1'b1; dsc_allow = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) drop_req();
            chk_idle_pins("both_allow");
        end

        // Enable with no allow: nothing happens.
        @(negedge clk);
        en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle_pins("no_allow");
        end
        en = 1'b0;

        // Reset in cycle 3 of a DSC write: killed with no done pulse.
        @(negedge clk);
        en = 1'b1; rw = 1'b1; dsc_allow = 1'b1; l2_allow = 1'b0;
        dsc_addr = 20'h54321; dsc_wdata = 16'h1234;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) drop_req();
        end
        chk("pre_kill_we_n", {31'd0, we_n}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("kill_we_n", {31'd0, we_n}, 32'd1);
        chk("kill_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("kill_ce_n", {31'd0, ce_n}, 32'd1);
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_addr", {12'd0, mem_addr}, 32'd0);
        chk("kill_done", {30'd0, l2_done, dsc_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        @(negedge clk);
        chk_idle_pins("post_kill");

        // Normal accesses after the killed one; the write checks rdata is held.
        access(1'b1, 1'b1, 20'h54321, 16'h1234, 16'h0000, 1'b0);
        access(1'b0, 1'b0, 20'h00ABC, 16'h0000, 16'h5AA5, 1'b0);
        access(1'b0, 1'b1, 20'h00001, 16'h8001, 16'h0000, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
